// File: rtl/conv_accel.sv
// 3x3 zero-padded convolution accelerator sharing one 8x8 multiplier; image and
// result kept in internal RAMs. Define CONV_SAT_EN to saturate results at 255.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | capturing N*N streamed pixels into the image RAM
// CALC  | 9 MAC cycles then 1 result-RAM write cycle per output pixel
// DONE  | all results written, done held until start or reset
module conv_accel #(
  parameter int N  = 28,
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            avail,
  output logic            done,
  output logic [DW-1:0]   result,
  input  logic [DW-1:0]   datain,
  output logic [DW-1:0]   dataout,
  input  logic            rd,
  input  logic [AW-1:0]   adr,
  input  logic [9*DW-1:0] kernel
);

  localparam int ACCW = 20;
  localparam logic [AW-1:0] LAST  = AW'(N*N-1);
  localparam logic [AW-1:0] NM1   = AW'(N-1);
  localparam logic [AW-1:0] NA    = AW'(N);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   y_q, y_d, x_q, x_d;
  logic [1:0]      r_q, r_d, c_q, c_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            avail_q, avail_d;
  logic            done_q, done_d;
  logic [DW-1:0]   result_q, result_d;

  logic [DW-1:0]   img_mem [2**AW];
  logic [DW-1:0]   res_mem [2**AW];

  logic [DW-1:0]   k_arr [9];
  logic [3:0]      k_idx;
  logic            row_ok, col_ok;
  logic [AW-1:0]   tap_addr, waddr;
  logic [DW-1:0]   pix;
  logic [2*DW-1:0] prod;

  always_comb begin
    for (int i = 0; i < 9; i++) k_arr[i] = kernel[i*DW +: DW];
  end

  // tap = img[(y+r-1)*N + (x+c-1)], forced to zero when it falls off the image
  assign k_idx    = {1'b0, r_q, 1'b0} + {2'b00, r_q} + {2'b00, c_q};
  assign row_ok   = !((y_q == '0 && r_q == 2'd0) || (y_q == NM1 && r_q == 2'd2));
  assign col_ok   = !((x_q == '0 && c_q == 2'd0) || (x_q == NM1 && c_q == 2'd2));
  assign tap_addr = (y_q + {{(AW-2){1'b0}}, r_q} - ONE_A) * NA
                  + (x_q + {{(AW-2){1'b0}}, c_q} - ONE_A);
  assign waddr    = y_q * NA + x_q;
  assign pix      = (row_ok && col_ok) ? img_mem[tap_addr] : '0;
  assign prod     = pix * k_arr[k_idx];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    x_d      = x_q;
    r_d      = r_q;
    c_d      = c_q;
    acc_d    = acc_q;
    avail_d  = 1'b0;
    done_d   = done_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        cnt_d = cnt_q + ONE_A;
        if (cnt_q == LAST) begin
          state_d = CALC;
          cnt_d   = '0;
          y_d     = '0;
          x_d     = '0;
          r_d     = 2'd0;
          c_d     = 2'd0;
        end
      end
      CALC: begin
        if (avail_q) begin
          if (x_q == NM1) begin
            x_d = '0;
            if (y_q == NM1) begin
              y_d     = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              y_d = y_q + ONE_A;
            end
          end else begin
            x_d = x_q + ONE_A;
          end
        end else begin
          acc_d = ((r_q == 2'd0 && c_q == 2'd0) ? '0 : acc_q)
                + {{(ACCW-2*DW){1'b0}}, prod};
          if (c_q == 2'd2) begin
            c_d = 2'd0;
            if (r_q == 2'd2) begin
              r_d     = 2'd0;
              avail_d = 1'b1;
`ifdef CONV_SAT_EN
              result_d = (|acc_d[ACCW-1:DW+7]) ? '1 : acc_d[DW+6:7];
`else
              result_d = acc_d[DW+6:7];
`endif
            end else begin
              r_d = r_q + 2'd1;
            end
          end else begin
            c_d = c_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      y_q      <= '0;
      x_q      <= '0;
      r_q      <= 2'd0;
      c_q      <= 2'd0;
      acc_q    <= '0;
      avail_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      x_q      <= x_d;
      r_q      <= r_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      avail_q  <= avail_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // RAMs are never cleared; writes are suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (rst && state_q == LOAD) img_mem[cnt_q] <= datain;
    if (rst && avail_q)         res_mem[waddr] <= result_q;
  end

  assign avail   = avail_q;
  assign done    = done_q;
  assign result  = result_q;
  assign dataout = rd ? res_mem[adr] : '0;

endmodule

// File: tb/tb_conv_accel.sv
// Scoreboard bench for conv_accel: expected pixels are queued as each image is
// streamed in and checked against result on every avail pulse.
module tb_conv_accel;

  localparam int N  = 28;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int NN = N * N;

  logic            clk = 1'b0;
  logic            rst, start, avail, done, rd;
  logic [DW-1:0]   result, datain, dataout;
  logic [AW-1:0]   adr;
  logic [9*DW-1:0] kernel;

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];
  int img_m[NN];
  int k_m[9];
  bit mon_en = 1'b0;
  int avail_cnt = 0;
  int cyc = 0;
  int t0;

  conv_accel #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .avail(avail), .done(done),
    .result(result), .datain(datain), .dataout(dataout), .rd(rd),
    .adr(adr), .kernel(kernel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_pix(int y, int x);
    int acc = 0;
    int v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int yy = y + r - 1;
        int xx = x + c - 1;
        if (yy >= 0 && yy < N && xx >= 0 && xx < N)
          acc += img_m[yy*N + xx] * k_m[3*r + c];
      end
    v = acc >> 7;
`ifdef CONV_SAT_EN
    return (v > 255) ? 255 : v;
`else
    return v & 255;
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en && avail) begin
      avail_cnt++;
      if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
      else chk("result", int'(result), sb.pop_front());
    end
  end

  task automatic set_kernel();
    for (int i = 0; i < 9; i++) kernel[i*DW +: DW] = DW'(k_m[i]);
  endtask

  task automatic begin_run();
    set_kernel();
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) sb.push_back(model_pix(y, x));
    avail_cnt = 0;
    mon_en    = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; datain = DW'(img_m[0]);
    t0 = cyc;
    for (int i = 1; i < NN; i++) begin
      @(posedge clk); #1 datain = DW'(img_m[i]);
    end
    @(posedge clk); #1 datain = '0;
  endtask

  task automatic finish_run(input string tag);
    while (!done && (cyc - t0) < 9000) @(negedge clk);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_avail_count"}, avail_cnt, NN);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    mon_en = 1'b0;
  endtask

  task automatic read_at(input int a, input logic en, output int v);
    rd  = en;
    adr = AW'(a);
    #1 v = int'(dataout);
  endtask

  initial begin
    int v;
    rst = 1'b0; start = 1'b0; rd = 1'b0; adr = '0; datain = '0; kernel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avail", int'(avail), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_dataout", int'(dataout), 0);
    rst = 1'b1;

    // uniform kernel, flat image: interior/edge/corner sums
    for (int i = 0; i < 9; i++) k_m[i] = 8'h0E;
    for (int i = 0; i < NN; i++) img_m[i] = 100;
    begin_run();
    finish_run("t1");
    read_at(0, 1'b1, v);   chk("t1_corner", v, 43);
    read_at(1, 1'b1, v);   chk("t1_edge", v, 65);
    read_at(29, 1'b0, v);  chk("t4_rd_low", v, 0);
    read_at(29, 1'b1, v);  chk("t4_interior", v, 98);
    rd = 1'b0;

    // identity kernel: result RAM mirrors the image
    for (int i = 0; i < 9; i++) k_m[i] = 0;
    k_m[4] = 8'h80;
    for (int i = 0; i < NN; i++) img_m[i] = i % 256;
    begin_run();
    finish_run("t2");
    for (int i = 0; i < NN; i++) begin
      read_at(i, 1'b1, v);
      chk("t2_readback", v, i % 256);
    end
    rd = 1'b0;

    // overflow beyond 8 bits
    for (int i = 0; i < 9; i++) k_m[i] = 8'h80;
    for (int i = 0; i < NN; i++) img_m[i] = 255;
    begin_run();
    finish_run("t3");
    read_at(29, 1'b1, v);
`ifdef CONV_SAT_EN
    chk("t3_interior", v, 255);
`else
    chk("t3_interior", v, 247);
`endif
    rd = 1'b0;

    // reset in the middle of CALC, then a fresh random run
    for (int i = 0; i < 9; i++) k_m[i] = $urandom_range(0, 255);
    for (int i = 0; i < NN; i++) img_m[i] = $urandom_range(0, 255);
    begin_run();
    for (int i = 0; i < 2000 && avail_cnt < 40; i++) @(negedge clk);
    chk("t5_pre_reset_pixels", int'(avail_cnt >= 40), 1);
    mon_en = 1'b0;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    chk("t5_rst_avail", int'(avail), 0);
    chk("t5_rst_done", int'(done), 0);
    chk("t5_rst_result", int'(result), 0);
    for (int i = 0; i < 9; i++) k_m[i] = $urandom_range(0, 255);
    for (int i = 0; i < NN; i++) img_m[i] = $urandom_range(0, 255);
    begin_run();
    finish_run("t5");

    // restart from DONE with a new image; a start pulse during CALC is ignored
    for (int i = 0; i < 9; i++) k_m[i] = $urandom_range(0, 255);
    for (int i = 0; i < NN; i++) img_m[i] = $urandom_range(0, 255);
    begin_run();
    chk("t6_done_dropped", int'(done), 0);
    repeat (500) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_run("t6");
    read_at(NN - 1, 1'b1, v);
    chk("t6_last_pixel", v, model_pix(N - 1, N - 1));
    rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
